// File: rtl/bfsdfs_pkg.sv
// Shared constants, types and address decode for the BFS/DFS traversal accelerator.
package bfsdfs_pkg;

    localparam int unsigned NODES       = 8;
    localparam int unsigned ADJ_BYTES   = 64;
    localparam int unsigned REG_BYTES   = 8;
    localparam int unsigned STORE_BYTES = ADJ_BYTES + 5 * REG_BYTES;
    localparam int unsigned IDX_W       = 7;

    // Byte offsets of each region inside the flat store.
    localparam logic [IDX_W-1:0] ADJ_OFS = 7'd0;
    localparam logic [IDX_W-1:0] VIS_OFS = 7'd64;
    localparam logic [IDX_W-1:0] QUE_OFS = 7'd72;
    localparam logic [IDX_W-1:0] STK_OFS = 7'd80;
    localparam logic [IDX_W-1:0] BFS_OFS = 7'd88;
    localparam logic [IDX_W-1:0] DFS_OFS = 7'd96;

    // Bit 8*i+j set iff edge i->j: undirected 0-1 0-2 1-3 1-4 2-5 2-6 3-7.
    localparam logic [ADJ_BYTES-1:0] DEFAULT_ADJ = 64'h0804_0402_8261_1906;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_BFS_DEQ,
        ST_BFS_SCAN,
        ST_CLEAR_VIS,
        ST_DFS_SCAN,
        ST_DONE
    } state_t;

    typedef logic [STORE_BYTES-1:0][7:0] store_t;

    typedef struct packed {
        logic             hit;
        logic             valid;
        logic [IDX_W-1:0] idx;
    } decode_t;

    typedef struct packed {
        logic             en;
        logic [IDX_W-1:0] idx;
        logic [7:0]       data;
    } wr_req_t;

    function automatic logic [IDX_W-1:0] at(input logic [IDX_W-1:0] base, input logic [2:0] n);
        return base + {4'd0, n};
    endfunction

    // Apertures 1..6 of 128 B each; 0 and 7 belong to other slaves.
    function automatic decode_t decode(input logic [9:0] addr);
        decode_t d;
        d.hit = (addr[9:7] != 3'd0) && (addr[9:7] != 3'd7);
        if (addr[9:7] == 3'd1) begin
            d.valid = d.hit && !addr[6];
            d.idx   = {1'b0, addr[5:0]};
        end else begin
            d.valid = d.hit && (addr[6:3] == 4'd0);
            d.idx   = 7'd48 + {1'b0, addr[9:7], addr[2:0]};
        end
        return d;
    endfunction

endpackage

// File: rtl/bfsdfs_mem_slave.sv
// Two-channel byte slave: decode, write request to the store, 1-cycle registered response.
module bfsdfs_mem_slave
    import bfsdfs_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic [1:0]    oe,
    input  logic [1:0]    we,
    input  logic [19:0]   addr,
    input  logic [15:0]   wdata,
    input  store_t        store,
    input  logic          wr_allow,
    output logic [15:0]   rdata,
    output logic [1:0]    rdy,
    output wr_req_t [1:0] wr_req_c
);

    decode_t [1:0] dec_c;

    // A strobe with both oe and we is served as a read only.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            dec_c[k]         = decode(addr[10*k +: 10]);
            wr_req_c[k].en   = we[k] && !oe[k] && dec_c[k].valid && wr_allow;
            wr_req_c[k].idx  = dec_c[k].idx;
            wr_req_c[k].data = wdata[8*k +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata <= '0;
            rdy   <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                rdy[k]          <= (oe[k] || we[k]) && dec_c[k].hit;
                rdata[8*k +: 8] <= (oe[k] && dec_c[k].valid) ? store[dec_c[k].idx] : 8'd0;
            end
        end
    end

endmodule

// File: rtl/bfsdfs_main.sv
// Graph traversal accelerator: BFS then DFS from node 0 over an 8-node adjacency matrix.
module bfsdfs_main
    import bfsdfs_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start_port,
    output logic        done_port,
    input  logic [1:0]  S_oe_ram,
    input  logic [1:0]  S_we_ram,
    input  logic [19:0] S_addr_ram,
    input  logic [15:0] S_Wdata_ram,
    input  logic [7:0]  S_data_ram_size,
    input  logic [15:0] M_Rdata_ram,
    input  logic [1:0]  M_DataRdy,
    output logic [15:0] Sout_Rdata_ram,
    output logic [1:0]  Sout_DataRdy,
    output logic [1:0]  Mout_oe_ram,
    output logic [1:0]  Mout_we_ram,
    output logic [19:0] Mout_addr_ram,
    output logic [15:0] Mout_Wdata_ram,
    output logic [7:0]  Mout_data_ram_size
);

    store_t        store;
    state_t        state;
    logic [3:0]    head, tail, sp, cnt;
    logic [2:0]    node, nbr;
    logic [2:0]    top_node, row;
    logic          edge_new;
    wr_req_t [1:0] wr_req_c;
    logic          unused_inputs;

    assign unused_inputs = ^{M_Rdata_ram, M_DataRdy, S_data_ram_size};

    assign Mout_oe_ram        = '0;
    assign Mout_we_ram        = '0;
    assign Mout_addr_ram      = '0;
    assign Mout_Wdata_ram     = '0;
    assign Mout_data_ram_size = '0;

    bfsdfs_mem_slave u_slave (
        .clock    (clock),
        .reset    (reset),
        .oe       (S_oe_ram),
        .we       (S_we_ram),
        .addr     (S_addr_ram),
        .wdata    (S_Wdata_ram),
        .store    (store),
        .wr_allow (state == ST_IDLE),
        .rdata    (Sout_Rdata_ram),
        .rdy      (Sout_DataRdy),
        .wr_req_c (wr_req_c)
    );

    // One adjacency byte per cycle: row is the dequeued node (BFS) or stack top (DFS).
    assign top_node = store[at(STK_OFS, 3'(sp - 4'd1))][2:0];
    assign row      = (state == ST_DFS_SCAN) ? top_node : node;
    assign edge_new = (store[{1'b0, row, nbr}] != 8'd0) && (store[at(VIS_OFS, nbr)] == 8'd0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            done_port <= 1'b0;
            head      <= '0;
            tail      <= '0;
            sp        <= '0;
            cnt       <= '0;
            node      <= '0;
            nbr       <= '0;
            store     <= '0;
            for (int i = 0; i < 64; i++) begin
                store[7'(i)] <= {7'd0, DEFAULT_ADJ[6'(i)]};
            end
        end else begin
            done_port <= 1'b0;
            // Slave writes are gated to IDLE in the slave; channel 1 is applied last.
            for (int k = 0; k < 2; k++) begin
                if (wr_req_c[k].en) store[wr_req_c[k].idx] <= wr_req_c[k].data;
            end
            case (state)
                ST_IDLE: begin
                    if (start_port) state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    for (int n = 0; n < 8; n++) begin
                        store[at(VIS_OFS, 3'(n))] <= 8'h00;
                        store[at(BFS_OFS, 3'(n))] <= 8'hFF;
                        store[at(DFS_OFS, 3'(n))] <= 8'hFF;
                    end
                    store[QUE_OFS] <= 8'd0;
                    store[VIS_OFS] <= 8'd1;
                    head  <= 4'd0;
                    tail  <= 4'd1;
                    cnt   <= 4'd0;
                    state <= ST_BFS_DEQ;
                end
                ST_BFS_DEQ: begin
                    if (head == tail) begin
                        state <= ST_CLEAR_VIS;
                    end else begin
                        node  <= store[at(QUE_OFS, head[2:0])][2:0];
                        store[at(BFS_OFS, cnt[2:0])] <= store[at(QUE_OFS, head[2:0])];
                        head  <= head + 4'd1;
                        cnt   <= cnt + 4'd1;
                        nbr   <= 3'd0;
                        state <= ST_BFS_SCAN;
                    end
                end
                ST_BFS_SCAN: begin
                    if (edge_new) begin
                        store[at(QUE_OFS, tail[2:0])] <= {5'd0, nbr};
                        store[at(VIS_OFS, nbr)]       <= 8'd1;
                        tail <= tail + 4'd1;
                    end
                    nbr <= nbr + 3'd1;
                    if (nbr == 3'd7) state <= ST_BFS_DEQ;
                end
                ST_CLEAR_VIS: begin
                    for (int n = 0; n < 8; n++) begin
                        store[at(VIS_OFS, 3'(n))] <= 8'h00;
                    end
                    store[VIS_OFS] <= 8'd1;
                    store[DFS_OFS] <= 8'd0;
                    store[STK_OFS] <= 8'd0;
                    sp    <= 4'd1;
                    cnt   <= 4'd1;
                    nbr   <= 3'd0;
                    state <= ST_DFS_SCAN;
                end
                // Push the first unvisited neighbour and rescan from it; pop when the row is exhausted.
                ST_DFS_SCAN: begin
                    if (edge_new) begin
                        store[at(VIS_OFS, nbr)]      <= 8'd1;
                        store[at(DFS_OFS, cnt[2:0])] <= {5'd0, nbr};
                        store[at(STK_OFS, sp[2:0])]  <= {5'd0, nbr};
                        cnt <= cnt + 4'd1;
                        sp  <= sp + 4'd1;
                        nbr <= 3'd0;
                    end else if (nbr == 3'd7) begin
                        sp  <= sp - 4'd1;
                        nbr <= 3'd0;
                        if (sp == 4'd1) state <= ST_DONE;
                    end else begin
                        nbr <= nbr + 3'd1;
                    end
                end
                ST_DONE: begin
                    done_port <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bfsdfs_main.sv
// Self-checking bench for bfsdfs_main against a queue-based BFS/DFS reference model.
module tb_bfsdfs_main;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_port = 1'b0;
    logic        done_port;
    logic [1:0]  S_oe_ram = '0;
    logic [1:0]  S_we_ram = '0;
    logic [19:0] S_addr_ram = '0;
    logic [15:0] S_Wdata_ram = '0;
    logic [7:0]  S_data_ram_size = 8'h88;
    logic [15:0] M_Rdata_ram = '0;
    logic [1:0]  M_DataRdy = '0;
    logic [15:0] Sout_Rdata_ram;
    logic [1:0]  Sout_DataRdy;
    logic [1:0]  Mout_oe_ram;
    logic [1:0]  Mout_we_ram;
    logic [19:0] Mout_addr_ram;
    logic [15:0] Mout_Wdata_ram;
    logic [7:0]  Mout_data_ram_size;

    bfsdfs_main dut (
        .clock              (clock),
        .reset              (reset),
        .start_port         (start_port),
        .done_port          (done_port),
        .S_oe_ram           (S_oe_ram),
        .S_we_ram           (S_we_ram),
        .S_addr_ram         (S_addr_ram),
        .S_Wdata_ram        (S_Wdata_ram),
        .S_data_ram_size    (S_data_ram_size),
        .M_Rdata_ram        (M_Rdata_ram),
        .M_DataRdy          (M_DataRdy),
        .Sout_Rdata_ram     (Sout_Rdata_ram),
        .Sout_DataRdy       (Sout_DataRdy),
        .Mout_oe_ram        (Mout_oe_ram),
        .Mout_we_ram        (Mout_we_ram),
        .Mout_addr_ram      (Mout_addr_ram),
        .Mout_Wdata_ram     (Mout_Wdata_ram),
        .Mout_data_ram_size (Mout_data_ram_size)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int master_bad = 0;

    bit         adj_m [8][8];
    logic [7:0] exp_bfs [8];
    logic [7:0] exp_dfs [8];
    logic [7:0] got_bfs [8];
    logic [7:0] got_dfs [8];
    logic [7:0] lit_bfs0 [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    logic [7:0] lit_dfs0 [8] = '{8'd0, 8'd1, 8'd3, 8'd7, 8'd4, 8'd2, 8'd5, 8'd6};
    logic [7:0] lit_bfs1 [8] = '{8'd0, 8'd1, 8'd3, 8'd4, 8'd7, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] lit_dfs1 [8] = '{8'd0, 8'd1, 8'd3, 8'd7, 8'd4, 8'hFF, 8'hFF, 8'hFF};

    always @(negedge clock) begin
        if (reset && ({Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size} !== '0))
            master_bad++;
    end

    task automatic model_default();
        int ea [7] = '{0, 0, 1, 1, 2, 2, 3};
        int eb [7] = '{1, 2, 3, 4, 5, 6, 7};
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) adj_m[i][j] = 1'b0;
        for (int e = 0; e < 7; e++) begin
            adj_m[ea[e]][eb[e]] = 1'b1;
            adj_m[eb[e]][ea[e]] = 1'b1;
        end
    endtask

    // BFS with a FIFO; DFS as "visit on pop, push neighbours high-to-low".
    task automatic compute_model();
        int q [$];
        bit vis [8];
        int n;
        int x;
        for (int i = 0; i < 8; i++) begin
            exp_bfs[i] = 8'hFF;
            exp_dfs[i] = 8'hFF;
            vis[i] = 1'b0;
        end
        n = 0;
        q.push_back(0);
        vis[0] = 1'b1;
        while (q.size() > 0) begin
            x = q.pop_front();
            exp_bfs[n] = 8'(x);
            n++;
            for (int j = 0; j < 8; j++) begin
                if (adj_m[x][j] && !vis[j]) begin
                    vis[j] = 1'b1;
                    q.push_back(j);
                end
            end
        end
        for (int i = 0; i < 8; i++) vis[i] = 1'b0;
        n = 0;
        q.push_back(0);
        while (q.size() > 0) begin
            x = q.pop_back();
            if (!vis[x]) begin
                vis[x] = 1'b1;
                exp_dfs[n] = 8'(x);
                n++;
                for (int j = 7; j >= 0; j--)
                    if (adj_m[x][j] && !vis[j]) q.push_back(j);
            end
        end
    endtask

    task automatic access2(input logic [1:0] oe, input logic [1:0] we,
                           input logic [9:0] a0, input logic [9:0] a1,
                           input logic [7:0] w0, input logic [7:0] w1,
                           output logic [7:0] d0, output logic [7:0] d1, output logic [1:0] r);
        @(negedge clock);
        S_oe_ram    = oe;
        S_we_ram    = we;
        S_addr_ram  = {a1, a0};
        S_Wdata_ram = {w1, w0};
        @(negedge clock);
        d0 = Sout_Rdata_ram[7:0];
        d1 = Sout_Rdata_ram[15:8];
        r  = Sout_DataRdy;
        S_oe_ram = '0;
        S_we_ram = '0;
    endtask

    task automatic fetch_orders();
        logic [7:0] d0, d1;
        logic [1:0] r;
        for (int i = 0; i < 8; i++) begin
            access2(2'b11, 2'b00, 10'(640 + i), 10'(768 + i), 8'd0, 8'd0, d0, d1, r);
            got_bfs[i] = d0;
            got_dfs[i] = d1;
        end
    endtask

    // Pulse start, then watch 500 cycles; optional extra start, busy-time write, mid-run reset.
    task automatic run(input int extra_start, input int mid_write, input int reset_at,
                       output int dones, output int lat, output logic wr_rdy, output logic rst_nz);
        dones  = 0;
        lat    = -1;
        wr_rdy = 1'b0;
        rst_nz = 1'b0;
        @(negedge clock);
        start_port = 1'b1;
        @(negedge clock);
        start_port = 1'b0;
        for (int c = 1; c <= 500; c++) begin
            if (done_port === 1'b1) begin
                dones++;
                if (lat < 0) lat = c;
            end
            if (reset_at > 0 && c == reset_at + 1)
                rst_nz = |{done_port, Sout_Rdata_ram, Sout_DataRdy};
            if (mid_write > 0 && c == mid_write + 1) wr_rdy = Sout_DataRdy[0];
            start_port  = (c == extra_start);
            S_we_ram[0] = (c == mid_write);
            if (c == mid_write) begin
                S_addr_ram[9:0]  = 10'd129;
                S_Wdata_ram[7:0] = 8'd0;
            end
            reset = (c != reset_at);
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d0, d1;
        logic [1:0] r;
        checks++;
        if ({done_port, Sout_Rdata_ram, Sout_DataRdy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got done=%b rdata=%h rdy=%b required 0", done_port, Sout_Rdata_ram, Sout_DataRdy);
        end
        access2(2'b11, 2'b00, 10'd129, 10'd640, 8'd0, 8'd0, d0, d1, r);
        checks++;
        if ({d0, d1, r} !== {8'd1, 8'd0, 2'b11}) begin
            errors++;
            $display("FAIL reset_regions: got adj=%h bfs=%h rdy=%b required 01 00 11", d0, d1, r);
        end
        access2(2'b11, 2'b00, 10'd256, 10'd768, 8'd0, 8'd0, d0, d1, r);
        checks++;
        if ({d0, d1} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_zeroed: got vis=%h dfs=%h required 00 00", d0, d1);
        end
    endtask

    task automatic test_default_run();
        int dones, lat;
        logic wr_rdy, rst_nz;
        run(-1, -1, -1, dones, lat, wr_rdy, rst_nz);
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL default_done_cycles: got %0d required 1", dones);
        end
        checks++;
        if (!(lat >= 1 && lat <= 400)) begin
            errors++;
            $display("FAIL default_latency: got %0d required 1..400", lat);
        end
        fetch_orders();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_bfs[i] !== lit_bfs0[i] || got_dfs[i] !== lit_dfs0[i]) begin
                errors++;
                $display("FAIL default_order[%0d]: got bfs=%h dfs=%h required bfs=%h dfs=%h",
                         i, got_bfs[i], got_dfs[i], lit_bfs0[i], lit_dfs0[i]);
            end
        end
    endtask

    task automatic test_slave_rw();
        logic [7:0] d0, d1;
        logic [1:0] r;
        access2(2'b11, 2'b00, 10'd129, 10'd130, 8'd0, 8'd0, d0, d1, r);
        checks++;
        if ({d0, d1, r} !== {8'd1, 8'd1, 2'b11}) begin
            errors++;
            $display("FAIL dual_read: got %h %h rdy=%b required 01 01 11", d0, d1, r);
        end
        access2(2'b11, 2'b00, 10'd900, 10'd50, 8'd0, 8'd0, d0, d1, r);
        checks++;
        if ({d0, d1, r} !== 18'd0) begin
            errors++;
            $display("FAIL unmapped_read: got %h %h rdy=%b required 00 00 00", d0, d1, r);
        end
        access2(2'b11, 2'b00, 10'd228, 10'd265, 8'd0, 8'd0, d0, d1, r);
        checks++;
        if ({d0, d1, r} !== {8'd0, 8'd0, 2'b11}) begin
            errors++;
            $display("FAIL unused_byte_read: got %h %h rdy=%b required 00 00 11", d0, d1, r);
        end
        access2(2'b00, 2'b11, 10'd137, 10'd137, 8'hA5, 8'h5A, d0, d1, r);
        checks++;
        if (r !== 2'b11) begin
            errors++;
            $display("FAIL write_rdy: got %b required 11", r);
        end
        access2(2'b01, 2'b00, 10'd137, 10'd0, 8'd0, 8'd0, d0, d1, r);
        checks++;
        if (d0 !== 8'h5A) begin
            errors++;
            $display("FAIL same_byte_ch1_wins: got %h required 5a", d0);
        end
        access2(2'b00, 2'b11, 10'd137, 10'd900, 8'h00, 8'h33, d0, d1, r);
        checks++;
        if (r !== 2'b01) begin
            errors++;
            $display("FAIL unmapped_write_rdy: got %b required 01", r);
        end
    endtask

    task automatic test_edit_graph();
        logic [7:0] d0, d1;
        logic [1:0] r;
        int dones, lat;
        logic wr_rdy, rst_nz;
        access2(2'b00, 2'b11, 10'd130, 10'd144, 8'd0, 8'd0, d0, d1, r);
        adj_m[0][2] = 1'b0;
        adj_m[2][0] = 1'b0;
        run(-1, -1, -1, dones, lat, wr_rdy, rst_nz);
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL edit_done_cycles: got %0d required 1", dones);
        end
        fetch_orders();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_bfs[i] !== lit_bfs1[i] || got_dfs[i] !== lit_dfs1[i]) begin
                errors++;
                $display("FAIL edit_order[%0d]: got bfs=%h dfs=%h required bfs=%h dfs=%h",
                         i, got_bfs[i], got_dfs[i], lit_bfs1[i], lit_dfs1[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] d0, d1;
        logic [1:0] r;
        int dones, lat;
        logic wr_rdy, rst_nz;
        compute_model();
        run(30, 40, -1, dones, lat, wr_rdy, rst_nz);
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL restart_done_cycles: got %0d required 1", dones);
        end
        checks++;
        if (wr_rdy !== 1'b1) begin
            errors++;
            $display("FAIL busy_write_rdy: got %b required 1", wr_rdy);
        end
        fetch_orders();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_bfs[i] !== exp_bfs[i] || got_dfs[i] !== exp_dfs[i]) begin
                errors++;
                $display("FAIL restart_order[%0d]: got bfs=%h dfs=%h required bfs=%h dfs=%h",
                         i, got_bfs[i], got_dfs[i], exp_bfs[i], exp_dfs[i]);
            end
        end
        access2(2'b01, 2'b00, 10'd129, 10'd0, 8'd0, 8'd0, d0, d1, r);
        checks++;
        if (d0 !== 8'd1) begin
            errors++;
            $display("FAIL busy_write_dropped: got %h required 01", d0);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] d0, d1;
        logic [1:0] r;
        int dones, lat;
        logic wr_rdy, rst_nz;
        run(-1, -1, 50, dones, lat, wr_rdy, rst_nz);
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done cycles required 0", dones);
        end
        checks++;
        if (rst_nz !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: got nonzero=%b required 0", rst_nz);
        end
        access2(2'b11, 2'b00, 10'd144, 10'd130, 8'd0, 8'd0, d0, d1, r);
        checks++;
        if ({d0, d1} !== 16'h0101) begin
            errors++;
            $display("FAIL abort_adj_restored: got %h %h required 01 01", d0, d1);
        end
        model_default();
        run(-1, -1, -1, dones, lat, wr_rdy, rst_nz);
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL rerun_done_cycles: got %0d required 1", dones);
        end
        fetch_orders();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_bfs[i] !== lit_bfs0[i] || got_dfs[i] !== lit_dfs0[i]) begin
                errors++;
                $display("FAIL rerun_order[%0d]: got bfs=%h dfs=%h required bfs=%h dfs=%h",
                         i, got_bfs[i], got_dfs[i], lit_bfs0[i], lit_dfs0[i]);
            end
        end
    endtask

    task automatic test_random_graphs();
        logic [7:0] d0, d1, v0, v1;
        logic [1:0] r;
        int dones, lat;
        logic wr_rdy, rst_nz;
        for (int it = 0; it < 5; it++) begin
            for (int k = 0; k < 32; k++) begin
                v0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
                v1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
                access2(2'b00, 2'b11, 10'(128 + k), 10'(160 + k), v0, v1, d0, d1, r);
                adj_m[k / 8][k % 8]       = (v0 != 8'd0);
                adj_m[(k + 32) / 8][k % 8] = (v1 != 8'd0);
            end
            compute_model();
            run(-1, -1, -1, dones, lat, wr_rdy, rst_nz);
            checks++;
            if (dones !== 1 || !(lat >= 1 && lat <= 400)) begin
                errors++;
                $display("FAIL random%0d_done: got cycles=%0d latency=%0d required 1 and 1..400", it, dones, lat);
            end
            fetch_orders();
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_bfs[i] !== exp_bfs[i] || got_dfs[i] !== exp_dfs[i]) begin
                    errors++;
                    $display("FAIL random%0d_order[%0d]: got bfs=%h dfs=%h required bfs=%h dfs=%h",
                             it, i, got_bfs[i], got_dfs[i], exp_bfs[i], exp_dfs[i]);
                end
            end
        end
    endtask

    task automatic test_master_idle();
        checks++;
        if (master_bad !== 0) begin
            errors++;
            $display("FAIL master_outputs_zero: got %0d nonzero cycles required 0", master_bad);
        end
    endtask

    initial begin
        model_default();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        test_reset();
        test_default_run();
        test_slave_rw();
        test_edit_graph();
        test_start_ignored();
        test_reset_mid_run();
        test_random_graphs();
        test_master_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
